// File: rtl/mac_vector.sv
// mac_vector
//   Streaming multiply-accumulate engine. Operand pairs arrive on a
//   valid/ready handshake. Their products are summed into a wide
//   accumulator, and one dot-product result is emitted per vector. A
//   vector is terminated by in_last.
//
//   Pipeline: S0 registered operands -> S1 product -> S2 accumulator/output.
//   Every stage moves only when advance = !out_valid || out_ready.
//
//   Compile-time option:
//     MAC_SATURATE_EN  defined   : accumulator clamps on overflow.
//                      undefined : accumulator wraps modulo 2^ACC_WIDTH.
//     In both builds, overflow reports the event sticky per vector.
//
//   Parameters:
//     DATA_WIDTH  operand width
//     ACC_WIDTH   accumulator/result width (>= 2*DATA_WIDTH)
//     CNT_WIDTH   element counter width (wraps)
//     SIGNED      1 = two's complement operands, 0 = unsigned
//
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-high reset
//     op_a, op_b            operand pair
//     in_valid, in_last     beat valid, final beat of vector
//     in_ready              beat can be accepted (combinational)
//     result, count         completed dot product and its element count
//     overflow              accumulator overflowed during that vector
//     out_valid, out_ready  output handshake
module mac_vector #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  result,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic                  advance;

    logic                  s0_valid;
    logic                  s0_last;
    logic [DATA_WIDTH-1:0] s0_a;
    logic [DATA_WIDTH-1:0] s0_b;

    logic                  s1_valid;
    logic                  s1_last;
    logic [PROD_WIDTH-1:0] s1_prod;

    logic [ACC_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  sticky;

    logic [PROD_WIDTH-1:0] a_ext;
    logic [PROD_WIDTH-1:0] b_ext;
    logic [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]  addend;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  carry;
    logic                  ovf_beat;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [CNT_WIDTH-1:0]  cnt_next;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // The operands are widened to the full product width before the multiply.
    // The low PROD_WIDTH bits of that product are then exact for both
    // signed and unsigned operands.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = {{DATA_WIDTH{s0_a[DATA_WIDTH-1]}}, s0_a};
            b_ext = {{DATA_WIDTH{s0_b[DATA_WIDTH-1]}}, s0_b};
        end else begin
            a_ext = {{DATA_WIDTH{1'b0}}, s0_a};
            b_ext = {{DATA_WIDTH{1'b0}}, s0_b};
        end
        prod = a_ext * b_ext;
    end

    always_comb begin
        // Sign extension is done by inverting twice. Zero-extending the
        // inverted product and then inverting it again fills the upper
        // bits with ones.
        if ((SIGNED != 0) && s1_prod[PROD_WIDTH-1])
            addend = ~ACC_WIDTH'(~s1_prod);
        else
            addend = ACC_WIDTH'(s1_prod);

        {carry, sum} = {1'b0, acc} + {1'b0, addend};

        if (SIGNED != 0)
            ovf_beat = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        else
            ovf_beat = carry;

        acc_next = sum;
`ifdef MAC_SATURATE_EN
        if (ovf_beat) begin
            if (SIGNED == 0)
                acc_next = '1;
            else if (addend[ACC_WIDTH-1])
                acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else
                acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
`endif
        cnt_next = cnt + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid  <= 1'b0;
            s0_last   <= 1'b0;
            s0_a      <= '0;
            s0_b      <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_prod   <= '0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            result    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s0_valid <= in_valid;
            s0_last  <= in_valid && in_last;
            if (in_valid) begin
                s0_a <= op_a;
                s0_b <= op_b;
            end

            s1_valid <= s0_valid;
            s1_last  <= s0_last;
            s1_prod  <= prod;

            if (s1_valid) begin
                if (s1_last) begin
                    // The result is handed off, and the accumulator is
                    // cleared on the same edge. The next vector therefore
                    // starts with no bubble.
                    result   <= acc_next;
                    count    <= cnt_next;
                    overflow <= sticky || ovf_beat;
                    acc      <= '0;
                    cnt      <= '0;
                    sticky   <= 1'b0;
                end else begin
                    acc    <= acc_next;
                    cnt    <= cnt_next;
                    sticky <= sticky || ovf_beat;
                end
            end

            // While advance is high, the output register is either being
            // consumed or is empty. It stays valid only if a new last beat
            // completes on this edge.
            out_valid <= s1_valid && s1_last;
        end
    end

endmodule
